// File: rtl/lamp_ctrl_exerciser.sv
// lamp_ctrl_exerciser: on-board stimulus and checker for the three-switch lamp
// controller. Sweeps {S3,S2,S1} through 000..111, holding each combination for
// DWELL cycles, samples F at dwell count SETTLE against odd parity, and reports
// a saturating mismatch count plus a registered pass flag.
//
// Optional build macro LAMP_EXERCISER_LOOP_EN: continuous-run mode. When start
// is high on the last cycle of step 7, the sweep wraps to step 0 without
// leaving RUN, done pulses for that cycle and err_cnt keeps accumulating.
//
// Handshake: start is a level request sampled only in IDLE; busy is high for
// the whole pass, done is a single-cycle pulse when a pass completes, and pass
// and err_cnt are valid from the edge that raises done.
//
// fsm_state exposes the controller state for debug and checker binding.

module lamp_ctrl_exerciser #(
   parameter int DWELL  = 50,
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       F,
   output logic       S1,
   output logic       S2,
   output logic       S3,
   output logic [2:0] step,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_cnt,
   output logic [1:0] fsm_state
);

   localparam int            CW         = $clog2(DWELL);
   localparam logic [CW-1:0] CNT_LAST   = CW'(DWELL - 1);
   localparam logic [CW-1:0] CNT_SETTLE = CW'(SETTLE);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] dwell_cnt;
   logic          mismatch;
   logic [3:0]    err_next;

   // F is judged against the parity of the switches currently being driven.
   assign mismatch = (state == ST_RUN) && (dwell_cnt == CNT_SETTLE) &&
                     (F != (S1 ^ S2 ^ S3));

   // Saturating count including this cycle's check, so a step-7 mismatch on
   // the final cycle still reaches the pass flag.
   assign err_next = (mismatch && (err_cnt != 4'hF)) ? err_cnt + 4'd1 : err_cnt;

   assign fsm_state = state;

   // Sequencer: IDLE -> RUN (eight dwell periods) -> DONE -> IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         dwell_cnt <= '0;
         step      <= 3'd0;
         S1        <= 1'b0;
         S2        <= 1'b0;
         S3        <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_cnt   <= 4'd0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_RUN;
                  dwell_cnt <= '0;
                  step      <= 3'd0;
                  S1        <= 1'b0;
                  S2        <= 1'b0;
                  S3        <= 1'b0;
                  busy      <= 1'b1;
                  err_cnt   <= 4'd0;
               end
            end

            ST_RUN: begin
               err_cnt <= err_next;
               if (dwell_cnt == CNT_LAST) begin
                  dwell_cnt <= '0;
                  if (step == 3'd7) begin
                     // End of a sweep: publish the result and return the
                     // switches to 000 whether we wrap or stop.
                     pass <= (err_next == 4'd0);
                     done <= 1'b1;
                     step <= 3'd0;
                     S1   <= 1'b0;
                     S2   <= 1'b0;
                     S3   <= 1'b0;
`ifdef LAMP_EXERCISER_LOOP_EN
                     if (!start) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                     end
`else
                     state <= ST_DONE;
                     busy  <= 1'b0;
`endif
                  end else begin
                     step <= step + 3'd1;
                     {S3, S2, S1} <= step + 3'd1;
                  end
               end else begin
                  dwell_cnt <= dwell_cnt + CW'(1);
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lamp_ctrl_exerciser.sv
// Testbench for lamp_ctrl_exerciser. A behavioural lamp model drives F from
// the switches with a per-combination fault mask (F = parity ^ mask[sw]).
// Expected outputs are derived from the cycle offset after the start edge:
// step = (j-1)/DWELL, and the error count after edge j is the number of
// faulty steps n whose check edge 2+n*DWELL+SETTLE is at or before j.

module tb_lamp_ctrl_exerciser;

   localparam int DWELL  = 4;
   localparam int SETTLE = 1;
   localparam int PASS_CYC = 8 * DWELL;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       f;
   logic       s1, s2, s3;
   logic [2:0] step;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] err_cnt;
   logic [1:0] fsm_state;

   logic [7:0] cur_mask;
   logic [4:0] exp_q[$];
   int         n_cmp;
   int         n_mis;

   lamp_ctrl_exerciser #(.DWELL(DWELL), .SETTLE(SETTLE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .F         (f),
      .S1        (s1),
      .S2        (s2),
      .S3        (s3),
      .step      (step),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_cnt   (err_cnt),
      .fsm_state (fsm_state)
   );

   // Clock and lamp-controller model
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign f = (s1 ^ s2 ^ s3) ^ cur_mask[{s3, s2, s1}];

   // Watchdog so the run always ends
   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Driver / checker helpers
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int fails_by(input logic [7:0] mask, input int j);
      int c = 0;
      for (int n = 0; n < 8; n++)
         if (mask[n] && (2 + n * DWELL + SETTLE <= j)) c++;
      return c;
   endfunction

   function automatic int sat15(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   function automatic int popcnt(input logic [7:0] m);
      int c = 0;
      for (int i = 0; i < 8; i++) if (m[i]) c++;
      return c;
   endfunction

   // Walks cycles j=1..jmax of a sweep whose start (or wrap) edge is the next
   // posedge. base is the error count carried in; wrapped marks a loop-mode
   // wrap edge, where done pulses while busy stays high.
   task automatic run_pass(input logic [7:0] mask, input int base, input bit wrapped,
                           input bit hold, input int jmax);
      int es;
      cur_mask = mask;
      for (int j = 1; j <= jmax; j++) begin
         @(posedge clk);
         @(negedge clk);
         if (j == 1) start = hold;
         es = (j - 1) / DWELL;
         check($sformatf("step j=%0d", j), 32'(step), 32'(es));
         check($sformatf("sw j=%0d", j), 32'({s3, s2, s1}), 32'(es));
         check($sformatf("busy j=%0d", j), 32'(busy), 32'd1);
         check($sformatf("done j=%0d", j), 32'(done), (j == 1 && wrapped) ? 32'd1 : 32'd0);
         check($sformatf("err j=%0d", j), 32'(err_cnt), 32'(sat15(base + fails_by(mask, j))));
         if (j == 1 && wrapped)
            check("pass_at_wrap", 32'(pass), (base == 0) ? 32'd1 : 32'd0);
      end
   endtask

   // Checks the DONE cycle and the first IDLE cycle after it.
   task automatic finish_pass(input int exp_err);
      logic [4:0] e;
      exp_q.push_back({(exp_err == 0), 4'(exp_err)});
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      check("done_pulse", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd0);
      check("done_sw", 32'({s3, s2, s1}), 32'd0);
      check("done_err", 32'(err_cnt), 32'(e[3:0]));
      check("done_pass", 32'(pass), 32'(e[4]));
      @(posedge clk);
      @(negedge clk);
      check("idle_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_err_hold", 32'(err_cnt), 32'(e[3:0]));
      check("idle_pass_hold", 32'(pass), 32'(e[4]));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_sw"}, 32'({s3, s2, s1}), 32'd0);
      check({tag, "_step"}, 32'(step), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_pass"}, 32'(pass), 32'd0);
      check({tag, "_err"}, 32'(err_cnt), 32'd0);
   endtask

   // Directed and randomized sequence
   initial begin
      logic [7:0] m;
      n_cmp    = 0;
      n_mis    = 0;
      cur_mask = 8'h00;
      rst_n    = 1'b0;
      start    = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Clean pass: correct XOR model
      start = 1'b1;
      run_pass(8'h00, 0, 1'b0, 1'b0, PASS_CYC);
      finish_pass(0);

      // F stuck at 0: fails on steps 1, 2, 4, 7
      start = 1'b1;
      run_pass(8'h96, 0, 1'b0, 1'b0, PASS_CYC);
      finish_pass(4);

      // Inverted model: every step fails
      start = 1'b1;
      run_pass(8'hFF, 0, 1'b0, 1'b0, PASS_CYC);
      finish_pass(8);

      // Random fault masks
      for (int r = 0; r < 4; r++) begin
         m = 8'($urandom_range(0, 255));
         start = 1'b1;
         run_pass(m, 0, 1'b0, 1'b0, PASS_CYC);
         finish_pass(popcnt(m));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // Reset in the middle of step 3, then a clean pass
      start = 1'b1;
      run_pass(8'hFF, 0, 1'b0, 1'b0, 3 * DWELL + 2);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_vals("midreset");
      rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         check("post_reset_done", 32'(done), 32'd0);
         check("post_reset_busy", 32'(busy), 32'd0);
      end
      start = 1'b1;
      run_pass(8'h00, 0, 1'b0, 1'b0, PASS_CYC);
      finish_pass(0);

      // start together with reset: reset wins
      rst_n = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("start_vs_reset_busy", 32'(busy), 32'd0);
      check("start_vs_reset_err", 32'(err_cnt), 32'd0);
      rst_n = 1'b1;
      start = 1'b0;
      @(negedge clk);

`ifdef LAMP_EXERCISER_LOOP_EN
      // Held start: wrap without an IDLE gap, err accumulates and saturates
      start = 1'b1;
      run_pass(8'hFF, 0, 1'b0, 1'b1, PASS_CYC);
      run_pass(8'hFF, 8, 1'b1, 1'b0, PASS_CYC);
      finish_pass(15);
`else
      // Held start: done, one IDLE cycle, then a fresh pass with err cleared
      start = 1'b1;
      run_pass(8'hFF, 0, 1'b0, 1'b1, PASS_CYC);
      @(posedge clk);
      @(negedge clk);
      check("held_done", 32'(done), 32'd1);
      check("held_done_busy", 32'(busy), 32'd0);
      check("held_done_err", 32'(err_cnt), 32'd8);
      check("held_done_pass", 32'(pass), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("held_idle_busy", 32'(busy), 32'd0);
      check("held_idle_done", 32'(done), 32'd0);
      check("held_idle_err", 32'(err_cnt), 32'd8);
      run_pass(8'hFF, 0, 1'b0, 1'b0, PASS_CYC);
      finish_pass(8);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/lamp_ctrl_exerciser.md
# lamp_ctrl_exerciser

On-board stimulus and checker for the three-switch lamp controller. The block drives the `S1`/`S2`/`S3` switch inputs of `LampCtrl` through all eight switch combinations, holding each for a programmable dwell time. At a fixed settle point in each step it samples the lamp output `F` against the expected odd-parity value. It reports an error count and a pass flag, so the lamp controller can be self-tested in hardware without a simulator.

## Interface
- `DWELL`, default 50: clock cycles each switch combination is held. Must be at least `SETTLE+1`.
- `SETTLE`, default 2: cycle index within a step at which `F` is sampled. Must be at least 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin one exercise pass; sampled only in IDLE.
- `F`  in  1  lamp output from the controller under test.
- `S1`, `S2`, `S3`  out  1 each  switch drives to the controller under test.
- `step`  out  3  current step index, equal to `{S3,S2,S1}` while busy.
- `busy`  out  1  a pass is in progress.
- `done`  out  1  one-cycle pulse at the end of a pass.
- `pass`  out  1  registered result of the last pass; 1 when the error count is 0.
- `err_cnt`  out  4  mismatches in the current or last pass; saturates at 15.

## Operation
- The FSM has three states.
  - IDLE to RUN when `start`=1. On entry, `err_cnt` is cleared and `step` and the dwell counter are set to 0.
  - RUN to RUN while `step` is less than 7 or the dwell counter is less than `DWELL-1`. When the dwell counter reaches `DWELL-1`, it returns to 0 and `step` increments.
  - RUN to DONE after the last cycle of step 7.
  - DONE to IDLE unconditionally.
- Switch drive: `{S3,S2,S1}` equals `step` in RUN and 3'b000 in IDLE and DONE. The sweep order is 000, 001, 010, 011, 100, 101, 110, 111, with `S1` as the LSB.
- Check: in RUN, when the dwell counter equals `SETTLE`, the block compares `F` with `S1^S2^S3`. On mismatch, `err_cnt` increments, saturating at 15.
- DONE state: `done`=1 and `busy`=0. `pass` is loaded with `(err_cnt==0)`, using the final count including any step-7 mismatch.
- `pass` and `err_cnt` hold their values in IDLE until the next `start`.
- `start` is ignored in RUN and DONE. It is level-sampled in IDLE, so if `start` is held high through DONE, a new pass begins on the first IDLE cycle.
- The dwell counter is `$clog2(DWELL)` bits wide and never exceeds `DWELL-1`.

## Timing
- All outputs are registered.
- Reset values: `S1`=`S2`=`S3`=0, `step`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, FSM in IDLE.
- `start` is seen high at edge k. From edge k+1 the block is in RUN with step 0 driven and `busy`=1.
- Step n occupies cycles k+1+n·DWELL through k+(n+1)·DWELL.
- `done` is high during the cycle after edge k+1+8·DWELL. The `pass` and `err_cnt` values are valid from the same edge.
- Sample latency: `F` is compared `SETTLE` cycles after the switches change. This allows `SETTLE-1` cycles for controller combinational and output-register delay.
- Reset mid-pass: at the next edge with `rst_n`=0, the switches go to 000, the FSM goes to IDLE and all outputs take their reset values. No `done` pulse is produced.
- `start` and `rst_n`=0 in the same cycle: reset wins.

## Configuration
- `LAMP_EXERCISER_LOOP_EN`: continuous-run mode.
- When the macro is defined:
  - On the last cycle of step 7, if `start`=1, the FSM stays in RUN, `step` wraps to 0, and `done` pulses for that one cycle while `busy` stays 1.
  - `pass` is updated at every wrap.
  - `err_cnt` accumulates across passes and is cleared only on entry from IDLE.
  - If `start`=0 at that point, the normal DONE path is taken.
- When the macro is not defined: a single pass per `start`, and `start` is ignored outside IDLE.

## Test plan
- Correct XOR model on `F`, `DWELL`=4, `SETTLE`=1, `start` pulsed at cycle 0:
  - the switches sweep 000 through 111, 4 cycles each;
  - `done`=1 at cycle 33;
  - `err_cnt`=0 and `pass`=1.
- `F` stuck at 0 -> `err_cnt`=4 (steps 1, 2, 4, 7) and `pass`=0.
- `F` inverted from the model -> `err_cnt`=8 and `pass`=0.
- `rst_n`=0 for one cycle during step 3:
  - all outputs return to reset values on the next edge, with no `done` pulse;
  - a following `start` runs a full clean pass with `pass`=1.
- `start` held high and inverted model, without the macro -> `done` pulses, followed by one IDLE cycle, then a new pass begins with `err_cnt` cleared to 0.
- `start` held high and inverted model, with `LAMP_EXERCISER_LOOP_EN` defined:
  - the sweep wraps with no IDLE gap and `busy` stays 1;
  - `err_cnt` is 8 after pass 1 and saturates at 15 during pass 2.
